// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl: arbitrates the instruction memory between a host program
// loader (write path) and CPU fetch (read path). Holds the core in reset while
// a program streams in, then releases it to fetch from word 0.
// Optional macro IMEM_LOAD_CHECKSUM_EN adds a running-sum output load_checksum.
module imem_load_ctrl #(
    parameter int MEMORY_SIZE = 64,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    localparam int PTR_W      = $clog2(MEMORY_SIZE),
    localparam int CNT_W      = $clog2(MEMORY_SIZE) + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  load_ready,
    input  logic [ADDR_WIDTH-1:0] cpu_fetch_addr,
    output logic [ADDR_WIDTH-1:0] imem_address,
    output logic                  imem_write_enabled,
    output logic [DATA_WIDTH-1:0] imem_input_data,
    output logic                  cpu_hold,
    output logic [CNT_W-1:0]      words_loaded,
    output logic                  load_error,
`ifdef IMEM_LOAD_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0] load_checksum,
`endif
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              hold_q, hold_d;
    logic              err_q, err_d;
    logic              accept;

    // Handshake and memory mux. Reset also blocks the beat so the reset edge
    // never writes memory.
    always_comb begin
        load_ready         = (state_q == S_LOAD) && !load_start && !reset;
        accept             = load_valid && load_ready;
        imem_write_enabled = accept;
        if (state_q == S_LOAD) begin
            imem_address    = ADDR_WIDTH'(ptr_q);
            imem_input_data = load_data;
        end else begin
            imem_address    = cpu_fetch_addr;
            imem_input_data = '0;
        end
    end

`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum_q, csum_d;

    // Running sum of accepted words; cleared by a new load, held otherwise.
    always_comb begin
        csum_d = csum_q;
        if (load_start)  csum_d = '0;
        else if (accept) csum_d = csum_q + load_data;
    end

    // Checksum register.
    always_ff @(posedge clock) begin
        if (reset) csum_q <= '0;
        else       csum_q <= csum_d;
    end

    assign load_checksum = csum_q;
`endif

    // Next-state logic: load_start beats any accept; ERROR and RUN only leave
    // through load_start (or reset).
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        err_d   = err_q;
        if (load_start) begin
            state_d = S_LOAD;
            ptr_d   = '0;
            cnt_d   = '0;
            hold_d  = 1'b1;
            err_d   = 1'b0;
        end else if (accept) begin
            ptr_d = ptr_q + PTR_W'(1);
            cnt_d = cnt_q + CNT_W'(1);
            if (load_last) begin
                state_d = S_RUN;
                hold_d  = 1'b0;
            end else if (ptr_q == PTR_W'(MEMORY_SIZE - 1)) begin
                state_d = S_ERROR;
                err_d   = 1'b1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            hold_q  <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
        end
    end

    assign cpu_hold     = hold_q;
    assign words_loaded = cnt_q;
    assign load_error   = err_q;
    assign state        = state_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Testbench for imem_load_ctrl: expected memory writes are queued as beats
// are driven and checked by a negedge monitor as the DUT issues them.
module tb_imem_load_ctrl;

    localparam int MS = 64;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = $clog2(MS) + 1;

    logic          clock = 1'b0;
    logic          reset, load_start, load_valid, load_last;
    logic [DW-1:0] load_data;
    logic [AW-1:0] cpu_fetch_addr;
    logic          load_ready, imem_write_enabled, cpu_hold, load_error;
    logic [AW-1:0] imem_address;
    logic [DW-1:0] imem_input_data;
    logic [CW-1:0] words_loaded;
    logic [1:0]    state;
`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [DW-1:0] load_checksum;
`endif

    imem_load_ctrl #(.MEMORY_SIZE(MS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock(clock), .reset(reset), .load_start(load_start),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready), .cpu_fetch_addr(cpu_fetch_addr),
        .imem_address(imem_address), .imem_write_enabled(imem_write_enabled),
        .imem_input_data(imem_input_data), .cpu_hold(cpu_hold),
        .words_loaded(words_loaded), .load_error(load_error),
`ifdef IMEM_LOAD_CHECKSUM_EN
        .load_checksum(load_checksum),
`endif
        .state(state)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  total  = 0;
    int  passed = 0;
    logic [DW-1:0] exp_sum;

    // Write monitor: every write the DUT issues must match the queue head.
    always @(negedge clock) begin
        if (imem_write_enabled === 1'b1) begin
            wr_t e;
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL write_unexpected: addr=%0h data=%0h, required no write", imem_address, imem_input_data);
            end else begin
                e = exp_q.pop_front();
                if (imem_address !== e.addr || imem_input_data !== e.data)
                    $display("FAIL write: addr=%0h data=%0h, required addr=%0h data=%0h",
                             imem_address, imem_input_data, e.addr, e.data);
                else passed++;
            end
        end
    end

    task automatic step();
        @(posedge clock); #1;
    endtask

    task automatic pulse_start();
        load_start = 1'b1; step(); load_start = 1'b0;
        exp_sum = '0;
    endtask

    // Drive one beat; when it will be accepted, queue the expected write.
    task automatic beat(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic last);
        load_valid = 1'b1; load_data = d; load_last = last;
        exp_q.push_back('{addr: a, data: d});
        exp_sum = exp_sum + d;
        step();
        load_valid = 1'b0; load_last = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; step(); step(); reset = 1'b0;
        @(negedge clock);
        total++;
        if (state !== 2'd0 || words_loaded !== '0 || cpu_hold !== 1'b1 || load_ready !== 1'b0 ||
            load_error !== 1'b0 || imem_write_enabled !== 1'b0)
            $display("FAIL reset: st=%0d wl=%0d hold=%b rdy=%b err=%b we=%b, required 0 0 1 0 0 0",
                     state, words_loaded, cpu_hold, load_ready, load_error, imem_write_enabled);
        else passed++;
        total++;
        cpu_fetch_addr = 32'h0000_0007;
        #1;
        if (imem_address !== 32'h7) $display("FAIL idle_passthru: addr=%0h, required 7", imem_address);
        else passed++;
        step();
    endtask

    task automatic test_basic();
        pulse_start();
        @(negedge clock);
        total++;
        if (state !== 2'd1 || load_ready !== 1'b1 || cpu_hold !== 1'b1)
            $display("FAIL basic_start: st=%0d rdy=%b hold=%b, required 1 1 1", state, load_ready, cpu_hold);
        else passed++;
        step();
        beat(0, 32'h2008_0005, 1'b0);
        beat(1, 32'h2009_0003, 1'b0);
        beat(2, 32'h0109_5020, 1'b1);
        @(negedge clock);
        total++;
        if (state !== 2'd2 || cpu_hold !== 1'b0 || words_loaded !== CW'(3) || load_ready !== 1'b0)
            $display("FAIL basic_run: st=%0d hold=%b wl=%0d rdy=%b, required 2 0 3 0",
                     state, cpu_hold, words_loaded, load_ready);
        else passed++;
        total++;
        cpu_fetch_addr = 32'h0; #1;
        if (imem_address !== 32'h0 || imem_input_data !== '0)
            $display("FAIL basic_fetch0: addr=%0h data=%0h, required 0 0", imem_address, imem_input_data);
        else passed++;
        total++;
        cpu_fetch_addr = 32'h2A; #1;
        if (imem_address !== 32'h2A) $display("FAIL basic_fetch: addr=%0h, required 2a", imem_address);
        else passed++;
        // A valid beat in RUN is ignored (monitor flags any write).
        load_valid = 1'b1; load_data = 32'hDEAD_BEEF; step(); load_valid = 1'b0;
        @(negedge clock);
        total++;
        if (words_loaded !== CW'(3)) $display("FAIL basic_hold_wl: wl=%0d, required 3", words_loaded);
        else passed++;
        step();
    endtask

    task automatic test_gapped();
        logic [5:0] pat;
        int a;
        pat = 6'b101001;  // bit0 first: 1,0,0,1,0,1
        a = 0;
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            if (pat[i]) begin
                beat(AW'(a), 32'h1000_0000 + DW'(i * 17), (i == 5));
                a++;
            end else step();
        end
        @(negedge clock);
        total++;
        if (state !== 2'd2 || words_loaded !== CW'(3))
            $display("FAIL gapped: st=%0d wl=%0d, required 2 3", state, words_loaded);
        else passed++;
`ifdef IMEM_LOAD_CHECKSUM_EN
        total++;
        if (load_checksum !== exp_sum)
            $display("FAIL gapped_csum: sum=%0h, required %0h", load_checksum, exp_sum);
        else passed++;
`endif
        step();
    endtask

    task automatic test_overflow();
        pulse_start();
        for (int i = 0; i < MS; i++) beat(AW'(i), 32'hA000_0000 + DW'(i), 1'b0);
        @(negedge clock);
        total++;
        if (state !== 2'd3 || load_error !== 1'b1 || cpu_hold !== 1'b1 || load_ready !== 1'b0 ||
            words_loaded !== CW'(64))
            $display("FAIL overflow: st=%0d err=%b hold=%b rdy=%b wl=%0d, required 3 1 1 0 64",
                     state, load_error, cpu_hold, load_ready, words_loaded);
        else passed++;
        load_valid = 1'b1; load_data = 32'h5555_5555; step(); load_valid = 1'b0;
        @(negedge clock);
        total++;
        if (state !== 2'd3 || words_loaded !== CW'(64))
            $display("FAIL overflow_65th: st=%0d wl=%0d, required 3 64", state, words_loaded);
        else passed++;
`ifdef IMEM_LOAD_CHECKSUM_EN
        total++;
        if (load_checksum !== exp_sum)
            $display("FAIL overflow_csum: sum=%0h, required %0h", load_checksum, exp_sum);
        else passed++;
`endif
        step();
    endtask

    task automatic test_reload();
        pulse_start();
        beat(0, 32'h1111_1111, 1'b1);
        @(negedge clock);
        total++;
        if (state !== 2'd2 || load_error !== 1'b0)
            $display("FAIL reload_first: st=%0d err=%b, required 2 0", state, load_error);
        else passed++;
        step();
        pulse_start();
        @(negedge clock);
        total++;
        if (state !== 2'd1 || cpu_hold !== 1'b1 || words_loaded !== '0)
            $display("FAIL reload_start: st=%0d hold=%b wl=%0d, required 1 1 0", state, cpu_hold, words_loaded);
        else passed++;
        step();
        beat(0, 32'h2222_2222, 1'b1);
        @(negedge clock);
        total++;
        if (state !== 2'd2 || cpu_hold !== 1'b0 || words_loaded !== CW'(1))
            $display("FAIL reload_run: st=%0d hold=%b wl=%0d, required 2 0 1", state, cpu_hold, words_loaded);
        else passed++;
        step();
    endtask

    task automatic test_simul();
        pulse_start();
        for (int i = 0; i < 5; i++) beat(AW'(i), 32'hC000_0000 + DW'(i), 1'b0);
        load_start = 1'b1; load_valid = 1'b1; load_data = 32'hBAD0_BAD0;
        @(negedge clock);
        total++;
        if (imem_write_enabled !== 1'b0 || load_ready !== 1'b0)
            $display("FAIL simul_nowrite: we=%b rdy=%b, required 0 0", imem_write_enabled, load_ready);
        else passed++;
        step();
        load_start = 1'b0; load_valid = 1'b0; exp_sum = '0;
        @(negedge clock);
        total++;
        if (state !== 2'd1 || words_loaded !== '0)
            $display("FAIL simul_restart: st=%0d wl=%0d, required 1 0", state, words_loaded);
        else passed++;
        step();
        beat(0, 32'h3333_3333, 1'b0);  // lands at pointer 0
        step();
    endtask

    task automatic test_reset_mid();
        pulse_start();
        beat(0, 32'h4444_0000, 1'b0);
        beat(1, 32'h4444_0001, 1'b0);
        reset = 1'b1; load_valid = 1'b1; load_data = 32'h4444_0002;
        @(negedge clock);
        total++;
        if (imem_write_enabled !== 1'b0)
            $display("FAIL resetmid_edge_we: we=%b, required 0", imem_write_enabled);
        else passed++;
        step();
        reset = 1'b0; load_valid = 1'b0;
        @(negedge clock);
        total++;
        if (state !== 2'd0 || words_loaded !== '0 || cpu_hold !== 1'b1 || imem_write_enabled !== 1'b0)
            $display("FAIL resetmid: st=%0d wl=%0d hold=%b we=%b, required 0 0 1 0",
                     state, words_loaded, cpu_hold, imem_write_enabled);
        else passed++;
`ifdef IMEM_LOAD_CHECKSUM_EN
        total++;
        if (load_checksum !== '0) $display("FAIL resetmid_csum: sum=%0h, required 0", load_checksum);
        else passed++;
`endif
        step();
    endtask

    initial begin
        reset = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
        load_data = '0; cpu_fetch_addr = '0; exp_sum = '0;
        test_reset();
        test_basic();
        test_gapped();
        test_overflow();
        test_reload();
        test_simul();
        test_reset_mid();
        total++;
        if (exp_q.size() != 0) $display("FAIL writes_missing: %0d outstanding, required 0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
